// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory: funct3 codes, FSM encoding,
// byte-lane mask and load-extension helpers.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   // Byte-lane write enables; unused codes behave as a full word.
   function automatic logic [3:0] wmask(input logic [2:0] f3, input logic [1:0] a);
      case (f3)
         F3_B, F3_BU: return 4'b0001 << a;
         F3_H, F3_HU: return a[1] ? 4'b1100 : 4'b0011;
         default:     return 4'b1111;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
      case (f3)
         F3_B, F3_BU: return 1'b0;
         F3_H, F3_HU: return a[0];
         default:     return (a != 2'b00);
      endcase
   endfunction

   // Replicate the store operand onto every lane it may land in.
   function automatic logic [31:0] wr_lanes(input logic [2:0] f3, input logic [31:0] d);
      case (f3)
         F3_B, F3_BU: return {4{d[7:0]}};
         F3_H, F3_HU: return {2{d[15:0]}};
         default:     return d;
      endcase
   endfunction

   function automatic logic [31:0] ld_extend(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{a, 3'b000} +: 8];
      h = a[1] ? w[31:16] : w[15:0];
      case (f3)
         F3_B:    return {{24{b[7]}}, b};
         F3_BU:   return {24'h0, b};
         F3_H:    return {{16{h[15]}}, h};
         F3_HU:   return {16'h0, h};
         default: return w;
      endcase
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables, async clear and
// combinational read of the addressed word.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_we,
   input  logic [3:0]       i_be,
   input  logic [IDX_W-1:0] i_idx,
   input  logic [31:0]      i_wdata,
   output logic [31:0]      o_rdata
);

   logic [31:0] r_mem [DEPTH_WORDS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= '0;
      end else if (i_we) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
         end
      end
   end

   assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/data_memory_ctrl.sv
// MEM-stage data memory controller: latches an aligned request, waits LATENCY
// cycles, performs the sub-word access and pulses done (or misaligned).
module data_memory_ctrl
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        busy,
   output logic        done,
   output logic        misaligned
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam int unsigned AW    = IDX_W + 2;
   localparam int unsigned CNT_W = 4;

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [AW-1:0]    r_addr;
   logic [2:0]       r_f3;
   logic [31:0]      r_wdata;
   logic             r_is_write;
   logic [31:0]      r_read_data, w_read_data_nxt;
   logic             r_done, w_done_nxt;
   logic             r_mis, w_mis_nxt;
   logic             w_latch;
   logic             w_req;
   logic             w_fire;
   logic [31:0]      w_rdata;
   logic             w_unused_addr;

   assign w_req         = mem_read | mem_write;
   assign w_fire        = (r_state == WAIT) && (r_cnt == '0);
   assign w_unused_addr = ^address[31:AW];

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk     (clk),
      .rst     (reset),
      .i_we    (w_fire & r_is_write),
      .i_be    (wmask(r_f3, r_addr[1:0])),
      .i_idx   (r_addr[AW-1:2]),
      .i_wdata (r_wdata),
      .o_rdata (w_rdata)
   );

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_addr      <= '0;
         r_f3        <= F3_W;
         r_wdata     <= '0;
         r_is_write  <= 1'b0;
         r_read_data <= '0;
         r_done      <= 1'b0;
         r_mis       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_read_data <= w_read_data_nxt;
         r_done      <= w_done_nxt;
         r_mis       <= w_mis_nxt;
         if (w_latch) begin
            r_addr     <= address[AW-1:0];
            r_f3       <= funct3;
            r_wdata    <= wr_lanes(funct3, write_data);
            r_is_write <= mem_write;
         end
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_read_data_nxt = r_read_data;
      w_done_nxt      = 1'b0;
      w_mis_nxt       = 1'b0;
      w_latch         = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req) begin
               if (is_misaligned(funct3, address[1:0])) begin
                  w_state_nxt = DONE;
                  w_mis_nxt   = 1'b1;
               end else begin
                  w_state_nxt = WAIT;
                  w_cnt_nxt   = CNT_W'(LATENCY - 1);
                  w_latch     = 1'b1;
               end
            end
         end
         WAIT: begin
            if (r_cnt == '0) begin
               w_state_nxt = DONE;
               w_done_nxt  = 1'b1;
               if (!r_is_write) w_read_data_nxt = ld_extend(r_f3, r_addr[1:0], w_rdata);
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign busy       = (r_state == WAIT) || ((r_state == IDLE) && w_req);
   assign read_data  = r_read_data;
   assign done       = r_done;
   assign misaligned = r_mis;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed self-checking bench for data_memory_ctrl (DEPTH_WORDS=256, LATENCY=2).
`timescale 1ns/1ps
module tb_data_memory_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read, mem_write;
   logic [2:0]  funct3;
   logic [31:0] address, write_data;
   logic [31:0] read_data;
   logic        busy, done, misaligned;

   int n_checks = 0;
   int n_fail   = 0;

   int         g_cyc;
   logic [7:0] g_busy;
   logic       g_done, g_mis, g_pre;

   data_memory_ctrl #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .funct3     (funct3),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .busy       (busy),
      .done       (done),
      .misaligned (misaligned)
   );

   always #5 clk = ~clk;

   // Issue one request, record busy per cycle and the cycle of the completion pulse.
   task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd);
      @(posedge clk); #1;
      mem_read = rd; mem_write = wr; funct3 = f3; address = a; write_data = wd;
      #1;
      g_busy = '0; g_busy[0] = busy; g_pre = done | misaligned;
      g_cyc = 20; g_done = 1'b0; g_mis = 1'b0;
      for (int k = 1; k < 20; k++) begin
         @(posedge clk); #1;
         if (k < 8) g_busy[k] = busy;
         if (done || misaligned) begin
            g_cyc = k; g_done = done; g_mis = misaligned;
            break;
         end
      end
      mem_read = 1'b0; mem_write = 1'b0;
   endtask

   task automatic check_ok_timing(input string nm);
      n_checks++;
      if (g_cyc !== 3 || g_done !== 1'b1 || g_mis !== 1'b0 || g_busy[3:0] !== 4'b0111 || g_pre !== 1'b0) begin
         n_fail++;
         $display("FAIL %s timing: cyc=%0d done=%b mis=%b busy=%b pre=%b, want cyc=3 done=1 mis=0 busy=0111 pre=0",
                  nm, g_cyc, g_done, g_mis, g_busy[3:0], g_pre);
      end
   endtask

   task automatic check_rd(input string nm, input logic [31:0] exp);
      n_checks++;
      if (read_data !== exp) begin
         n_fail++;
         $display("FAIL %s read_data: got=%h want=%h", nm, read_data, exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b010;
      address = '0; write_data = '0;
      #12;
      n_checks++;
      if (read_data !== 32'h0 || done !== 1'b0 || misaligned !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: rd=%h done=%b mis=%b busy=%b want 0/0/0/0",
                  read_data, done, misaligned, busy);
      end
      @(posedge clk); #1; reset = 1'b0;
   endtask

   task automatic test_first_load();
      do_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
      check_ok_timing("lw_0x10");
      check_rd("lw_0x10", 32'h0000_0000);
   endtask

   task automatic test_subword();
      do_access(1'b0, 1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF);
      check_ok_timing("sw_0x20");
      check_rd("sw_keeps_rd", 32'h0000_0000);
      do_access(1'b1, 1'b0, 3'b000, 32'h23, 32'h0);
      check_rd("lb_0x23", 32'hFFFF_FFDE);
      do_access(1'b1, 1'b0, 3'b100, 32'h23, 32'h0);
      check_rd("lbu_0x23", 32'h0000_00DE);
      do_access(1'b1, 1'b0, 3'b001, 32'h22, 32'h0);
      check_rd("lh_0x22", 32'hFFFF_DEAD);
      do_access(1'b1, 1'b0, 3'b101, 32'h20, 32'h0);
      check_ok_timing("lhu_0x20");
      check_rd("lhu_0x20", 32'h0000_BEEF);
   endtask

   task automatic test_sb();
      do_access(1'b0, 1'b1, 3'b000, 32'h21, 32'hAAAA_BB55);
      do_access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
      check_rd("sb_merge", 32'hDEAD_55EF);
   endtask

   task automatic test_rw_conflict();
      do_access(1'b1, 1'b1, 3'b010, 32'h40, 32'hA5A5_5A5A);
      check_ok_timing("rw_store");
      check_rd("rw_keeps_rd", 32'hDEAD_55EF);
      do_access(1'b1, 1'b0, 3'b011, 32'h40, 32'h0);
      check_rd("f3_011_as_lw", 32'hA5A5_5A5A);
      do_access(1'b1, 1'b0, 3'b101, 32'h42, 32'h0);
      check_rd("lhu_0x42", 32'h0000_A5A5);
      do_access(1'b1, 1'b0, 3'b000, 32'h40, 32'h0);
      check_rd("lb_0x40_pos", 32'h0000_005A);
   endtask

   task automatic test_misaligned();
      do_access(1'b1, 1'b0, 3'b010, 32'h22, 32'h0);
      n_checks++;
      if (g_cyc !== 1 || g_mis !== 1'b1 || g_done !== 1'b0 || g_busy[1:0] !== 2'b01) begin
         n_fail++;
         $display("FAIL mis_lw timing: cyc=%0d mis=%b done=%b busy=%b want 1/1/0/01",
                  g_cyc, g_mis, g_done, g_busy[1:0]);
      end
      check_rd("mis_lw_keeps_rd", 32'h0000_005A);
      do_access(1'b0, 1'b1, 3'b001, 32'h13, 32'h0000_FFFF);
      n_checks++;
      if (g_cyc !== 1 || g_mis !== 1'b1 || g_done !== 1'b0 || g_busy[1:0] !== 2'b01) begin
         n_fail++;
         $display("FAIL mis_sh timing: cyc=%0d mis=%b done=%b busy=%b want 1/1/0/01",
                  g_cyc, g_mis, g_done, g_busy[1:0]);
      end
      do_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
      check_ok_timing("lw_after_mis");
      check_rd("mis_sh_no_write", 32'h0000_0000);
      do_access(1'b1, 1'b0, 3'b000, 32'h23, 32'h0);
      check_rd("lb_odd_aligned", 32'hFFFF_FFDE);
   endtask

   task automatic test_wrap();
      do_access(1'b0, 1'b1, 3'b010, 32'h0000_0408, 32'h1234_5678);
      do_access(1'b1, 1'b0, 3'b010, 32'h8, 32'h0);
      check_rd("wrap_lw_0x8", 32'h1234_5678);
   endtask

   task automatic test_reset_in_wait();
      @(posedge clk); #1;
      mem_write = 1'b1; funct3 = 3'b010; address = 32'h30; write_data = 32'hCAFE_BABE;
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL wait_busy: got=%b want=1", busy);
      end
      mem_write = 1'b0; reset = 1'b1;
      #1;
      n_checks++;
      if (read_data !== 32'h0 || done !== 1'b0 || misaligned !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_in_wait: rd=%h done=%b mis=%b busy=%b want 0/0/0/0",
                  read_data, done, misaligned, busy);
      end
      @(posedge clk); #1; reset = 1'b0;
      do_access(1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
      check_ok_timing("lw_0x30_after_reset");
      check_rd("store_dropped", 32'h0000_0000);
      do_access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
      check_rd("mem_cleared", 32'h0000_0000);
   endtask

   initial begin
      test_reset();
      test_first_load();
      test_subword();
      test_sb();
      test_rw_conflict();
      test_misaligned();
      test_wrap();
      test_reset_in_wait();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
